// File: rtl/refclk_gen_if.sv
// Control/status bundle for refclk_gen: per-channel enable, load and divisor in;
// tick, pending and square-wave strobes out.
interface refclk_gen_if #(
   parameter int NCH = 4,
   parameter int BW  = 8
);
   logic [NCH-1:0]    en_i;
   logic [NCH-1:0]    ld_i;
   logic [NCH*BW-1:0] div_i;
   logic              sync_i;
   logic [NCH-1:0]    tick_o;
   logic [NCH-1:0]    pend_o;
   logic [NCH-1:0]    sq_o;

   modport master (
      output en_i, ld_i, div_i, sync_i,
      input  tick_o, pend_o, sq_o
   );

   modport slave (
      input  en_i, ld_i, div_i, sync_i,
      output tick_o, pend_o, sq_o
   );
endinterface

// File: rtl/refclk_gen.sv
// Multi-channel reference-tick generator with shadowed runtime divisors.
// Define REFCLK_GEN_SQ_EN to add the per-channel 50% duty square-wave output.
module refclk_gen_ch #(
   parameter int BW      = 8,
   parameter int DEF_DIV = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          ld_i,
   input  logic [BW-1:0] div_i,
   input  logic          sync_i,
   output logic          tick_o,
   output logic          pend_o,
   output logic          sq_o
);
   localparam logic [BW-1:0] ONE = BW'(1);

   logic [BW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] act_q, act_d;
   logic [BW-1:0] shd_q, shd_d;
   logic [BW-1:0] nxt;
   logic          pend_q, pend_d;
   logic          tick_q, tick_d;
`ifdef REFCLK_GEN_SQ_EN
   logic          sq_q, sq_d;
`endif

   always_comb begin
      nxt    = pend_q ? shd_q : act_q;
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
`ifdef REFCLK_GEN_SQ_EN
      sq_d   = sq_q;
`endif
      // Restart (sync, disabled or idle divisor) reloads a full period and lands any pending divisor
      if (sync_i || !en_i || act_q == '0) begin
         cnt_d  = nxt - ONE;
         act_d  = nxt;
         pend_d = 1'b0;
`ifdef REFCLK_GEN_SQ_EN
         sq_d   = 1'b0;
`endif
      end else if (cnt_q == '0) begin
         cnt_d  = nxt - ONE;
         act_d  = nxt;
         pend_d = 1'b0;
         tick_d = 1'b1;
`ifdef REFCLK_GEN_SQ_EN
         sq_d   = ~sq_q;
`endif
      end else begin
         cnt_d  = cnt_q - ONE;
      end
      // A same-edge load is only captured in the shadow; it waits for the following wrap
      if (ld_i) begin
         shd_d  = div_i;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= BW'(DEF_DIV - 1);
         act_q  <= BW'(DEF_DIV);
         shd_q  <= BW'(DEF_DIV);
         pend_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
      end
   end

`ifdef REFCLK_GEN_SQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sq_q <= 1'b0;
      else        sq_q <= sq_d;
   end
   assign sq_o = sq_q;
`else
   assign sq_o = 1'b0;
`endif

   assign tick_o = tick_q;
   assign pend_o = pend_q;
endmodule

module refclk_gen #(
   parameter int NCH     = 4,
   parameter int BW      = 8,
   parameter int DEF_DIV = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   refclk_gen_if.slave bus
);
   logic [NCH-1:0] tick, pend, sq;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      refclk_gen_ch #(.BW(BW), .DEF_DIV(DEF_DIV)) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_i   (bus.en_i[c]),
         .ld_i   (bus.ld_i[c]),
         .div_i  (bus.div_i[c*BW +: BW]),
         .sync_i (bus.sync_i),
         .tick_o (tick[c]),
         .pend_o (pend[c]),
         .sq_o   (sq[c])
      );
   end

   assign bus.tick_o = tick;
   assign bus.pend_o = pend;
   assign bus.sq_o   = sq;
endmodule

// File: tb/tb_refclk_gen.sv
// Directed table of per-edge inputs/expected tick and pend, plus reset and square-wave sequences.
module tb_refclk_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   ntests = 0;
   int   nfail  = 0;

   refclk_gen_if #(.NCH(4), .BW(8)) bus ();

   refclk_gen #(.NCH(4), .BW(8), .DEF_DIV(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] en;
      logic [3:0] ld;
      logic [31:0] div;
      logic       sync;
      logic [3:0] tick;
      logic [3:0] pend;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] dv(input logic [7:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   task automatic add(input string n, input logic [3:0] en, ld, input logic [31:0] div,
                      input logic sync, input logic [3:0] tick, pend);
      vec_t v;
      v.name = n; v.en = en; v.ld = ld; v.div = div; v.sync = sync; v.tick = tick; v.pend = pend;
      tbl.push_back(v);
   endtask

   task automatic chk(input string n, input logic [3:0] got, input logic [3:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %b expected %b", n, got, exp);
      end
   endtask

   initial begin
      logic [3:0] sq_exp;
      bus.en_i = '0; bus.ld_i = '0; bus.div_i = '0; bus.sync_i = 1'b0;

      // scenario 1: default divisor 2 on ch0
      add("s1_e1", 4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s1_e2", 4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0001, 4'b0000);
      add("s1_e3", 4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s1_e4", 4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0001, 4'b0000);
      add("s1_e5", 4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      // scenario 2: ch1 div 3, reload 5 mid-period
      add("s2_ld3", 4'b0000, 4'b0010, dv(0,3,0,0), 1'b0, 4'b0000, 4'b0010);
      add("s2_apl", 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s2_e1",  4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s2_e2",  4'b0010, 4'b0010, dv(0,5,0,0), 1'b0, 4'b0000, 4'b0010);
      add("s2_e3",  4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0010, 4'b0000);
      for (int i = 4; i <= 7; i++)
         add($sformatf("s2_e%0d", i), 4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s2_e8",  4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0010, 4'b0000);
      add("s2_e9",  4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s2_off", 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      // scenario 3: ch0 div 4, ch2 div 6, sync re-phase, load on wrap edge
      add("s3_ld",  4'b0000, 4'b0101, dv(4,0,6,0), 1'b0, 4'b0000, 4'b0101);
      add("s3_apl", 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      for (int i = 1; i <= 3; i++)
         add($sformatf("s3_e%0d", i), 4'b0101, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s3_sync", 4'b0101, 4'b0000, 32'h0, 1'b1, 4'b0000, 4'b0000);
      for (int i = 5; i <= 7; i++)
         add($sformatf("s3_e%0d", i), 4'b0101, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s3_e8_ldwrap", 4'b0101, 4'b0001, dv(2,0,0,0), 1'b0, 4'b0001, 4'b0001);
      add("s3_e9",  4'b0101, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0001);
      add("s3_e10", 4'b0101, 4'b0000, 32'h0, 1'b0, 4'b0100, 4'b0001);
      add("s3_e11", 4'b0101, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0001);
      add("s3_e12", 4'b0101, 4'b0000, 32'h0, 1'b0, 4'b0001, 4'b0000);
      add("s3_e13", 4'b0101, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s3_e14", 4'b0101, 4'b0000, 32'h0, 1'b0, 4'b0001, 4'b0000);
      add("s3_off", 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      // scenario 4: div 1 constant tick, div 0 idle, enable toggle restarts period
      add("s4_ld1", 4'b0000, 4'b1000, dv(0,0,0,1), 1'b0, 4'b0000, 4'b1000);
      add("s4_apl", 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      for (int i = 1; i <= 3; i++)
         add($sformatf("s4_d1_e%0d", i), 4'b1000, 4'b0000, 32'h0, 1'b0, 4'b1000, 4'b0000);
      add("s4_ld0", 4'b1000, 4'b1000, dv(0,0,0,0), 1'b0, 4'b1000, 4'b1000);
      add("s4_wrp0", 4'b1000, 4'b0000, 32'h0, 1'b0, 4'b1000, 4'b0000);
      add("s4_idle1", 4'b1000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s4_idle2", 4'b1000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s4_t_e1", 4'b0100, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s4_t_e2", 4'b0100, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s4_t_off", 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      for (int i = 4; i <= 8; i++)
         add($sformatf("s4_t_e%0d", i), 4'b0100, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s4_t_e9", 4'b0100, 4'b0000, 32'h0, 1'b0, 4'b0100, 4'b0000);
      add("s4_off", 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      // scenario 5 prelude: ch1 div 7 counting down to 2, ch3 load pending
      add("s5_ld7", 4'b0000, 4'b0010, dv(0,7,0,0), 1'b0, 4'b0000, 4'b0010);
      add("s5_apl", 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s5_e1",  4'b0011, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s5_e2",  4'b0011, 4'b0000, 32'h0, 1'b0, 4'b0001, 4'b0000);
      add("s5_e3",  4'b0011, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);
      add("s5_e4",  4'b0011, 4'b1000, dv(0,0,0,9), 1'b0, 4'b0001, 4'b1000);

      // reset state
      #12;
      chk("rst_tick", bus.tick_o, 4'b0000);
      chk("rst_pend", bus.pend_o, 4'b0000);
      chk("rst_sq",   bus.sq_o,   4'b0000);
      @(negedge clk) rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         bus.en_i = tbl[i].en; bus.ld_i = tbl[i].ld; bus.div_i = tbl[i].div; bus.sync_i = tbl[i].sync;
         @(posedge clk); #1;
         chk({tbl[i].name, "_tick"}, bus.tick_o, tbl[i].tick);
         chk({tbl[i].name, "_pend"}, bus.pend_o, tbl[i].pend);
      end

      // asynchronous reset mid-count, then first tick after DEF_DIV edges
      #1 rst_n = 1'b0;
      #1;
      chk("arst_tick", bus.tick_o, 4'b0000);
      chk("arst_pend", bus.pend_o, 4'b0000);
      @(negedge clk) begin bus.ld_i = '0; bus.en_i = 4'b0011; end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_rel_e1", bus.tick_o, 4'b0000);
      @(posedge clk); #1;
      chk("arst_rel_e2", bus.tick_o, 4'b0011);

      // square wave on ch2 with div 3
      @(negedge clk) begin bus.en_i = '0; bus.ld_i = 4'b0100; bus.div_i = dv(0,0,3,0); end
      @(negedge clk) bus.ld_i = '0;
      @(negedge clk) bus.en_i = 4'b0100;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk($sformatf("sq_tick_e%0d", k), bus.tick_o, (k % 3 == 0) ? 4'b0100 : 4'b0000);
`ifdef REFCLK_GEN_SQ_EN
         sq_exp = ((k >= 3 && k <= 5) || (k >= 9 && k <= 11)) ? 4'b0100 : 4'b0000;
`else
         sq_exp = 4'b0000;
`endif
         chk($sformatf("sq_e%0d", k), bus.sq_o, sq_exp);
      end
      @(negedge clk) bus.en_i = '0;
      @(posedge clk); #1;
      chk("sq_clr_off", bus.sq_o, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
